// File: rtl/timestamp_capture.sv
`default_nettype none
// ============================================================================
// Module   : timestamp_capture
// Brief    : Synchronises an event line, captures {overflow, count} on each
//            rising edge into a first-word-fall-through FIFO, counts drops.
// Revision : 1.0  initial release
// ============================================================================
module timestamp_capture #(
    parameter int W           = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   event_in,
    input  logic [W-1:0]           count,
    input  logic                   overflow,
    input  logic                   out_ready,
    input  logic                   drop_clr,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    output logic                   out_ovf,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             drop_cnt
);
    localparam int C_PW = $clog2(DEPTH);
    localparam int C_LW = C_PW + 1;
    localparam logic [C_LW-1:0] C_FULL = C_LW'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   hist_q, hist_d;
    logic                   armed_q, armed_d;
    logic [W:0]             mem_q [DEPTH];
    logic [W:0]             mem_d [DEPTH];
    logic [C_PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [C_PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [C_LW-1:0]        level_q, level_d;
    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           out_data_q, out_data_d;
    logic                   out_ovf_q, out_ovf_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    logic w_cap, w_pop, w_full, w_push, w_drop, w_mem_nonempty, w_load;

    // vld tracks which sync stages hold real samples rather than reset zeros,
    // so an input held high through reset is not mistaken for a rising edge.
    assign w_cap          = sync_q[SYNC_STAGES-1] & ~hist_q & armed_q;
    assign w_pop          = out_valid_q & out_ready;
    assign w_full         = (level_q == C_FULL);
    assign w_push         = w_cap & (~w_full | w_pop);
    assign w_drop         = w_cap & w_full & ~w_pop;
    assign w_mem_nonempty = (level_q != C_LW'(out_valid_q));
    assign w_load         = w_mem_nonempty & (~out_valid_q | w_pop);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], event_in};
        vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
        hist_d  = sync_q[SYNC_STAGES-1];
        armed_d = armed_q | (vld_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
    end

    // The head lives in the output register; the array holds the rest.
    always_comb begin
        mem_d = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {overflow, count};
        end
        wr_ptr_d    = wr_ptr_q + C_PW'(w_push);
        rd_ptr_d    = rd_ptr_q + C_PW'(w_load);
        level_d     = level_q + C_LW'(w_push) - C_LW'(w_pop);
        out_valid_d = w_load | (out_valid_q & ~w_pop);
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (w_load) begin
            {out_ovf_d, out_data_d} = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_clr) begin
            drop_cnt_d = w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            vld_q       <= '0;
            hist_q      <= 1'b0;
            armed_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            sync_q      <= sync_d;
            vld_q       <= vld_d;
            hist_q      <= hist_d;
            armed_q     <= armed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign level     = level_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_timestamp_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_timestamp_capture
// Brief    : Self-checking bench with a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_timestamp_capture;
    localparam int W           = 32;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, event_in, overflow, out_ready, drop_clr;
    logic [W-1:0]  count;
    logic          out_valid, out_ovf;
    logic [W-1:0]  out_data;
    logic [LW-1:0] level;
    logic [7:0]    drop_cnt;

    timestamp_capture #(
        .W           (W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .event_in  (event_in),
        .count     (count),
        .overflow  (overflow),
        .out_ready (out_ready),
        .drop_clr  (drop_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         ovf;
        logic [W-1:0] data;
        int           t;
    } ent_t;

    // Model: FIFO of entries stamped with their push edge; an entry is visible
    // at the head once an edge has passed since it was pushed.
    ent_t         mq[$];
    bit           evs[$];
    int           t_edge;
    bit           m_valid;
    logic [W-1:0] m_data;
    logic         m_ovf;
    int           m_dc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        evs.delete();
        t_edge  = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_dc    = 0;
    endtask

    task automatic model_step();
        bit   pop, cap, full, drop;
        ent_t e;
        t_edge++;
        pop = m_valid && out_ready;
        evs.push_back(event_in);
        if (evs.size() > SYNC_STAGES + 2) void'(evs.pop_front());
        // Rising edge between two genuine samples, SYNC_STAGES edges ago.
        cap  = (evs.size() == SYNC_STAGES + 2) && evs[1] && !evs[0];
        full = (mq.size() == DEPTH);
        drop = 1'b0;
        if (pop) void'(mq.pop_front());
        if (cap) begin
            if (!full || pop) begin
                e.ovf  = overflow;
                e.data = count;
                e.t    = t_edge;
                mq.push_back(e);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop_clr) m_dc = drop ? 1 : 0;
        else if (drop) m_dc = (m_dc == 255) ? 255 : m_dc + 1;
        m_valid = (mq.size() > 0) && (mq[0].t < t_edge);
        if (m_valid) begin
            m_data = mq[0].data;
            m_ovf  = mq[0].ovf;
        end
    endtask

    task automatic compare();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("level",     64'(level),     64'(mq.size()));
        chk("drop_cnt",  64'(drop_cnt),  64'(m_dc));
        chk("out_data",  64'(out_data),  64'(m_data));
        chk("out_ovf",   64'(out_ovf),   64'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic pulse(input int hi, input int lo);
        event_in = 1'b1;
        repeat (hi) cycle();
        event_in = 1'b0;
        repeat (lo) cycle();
    endtask

    initial begin
        int lat;
        reset = 1'b1; event_in = 1'b1; count = '0; overflow = 1'b0;
        out_ready = 1'b0; drop_clr = 1'b0;
        model_reset();
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_data",  64'(out_data), 64'd0);
        repeat (3) cycle();
        reset = 1'b0;
        repeat (10) cycle();
        chk("held_high_no_cap", 64'(level), 64'd0);

        // Single 3-wide pulse with a steady count
        event_in = 1'b0; count = W'(100);
        repeat (3) cycle();
        event_in = 1'b1; lat = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) event_in = 1'b0;
            cycle();
            if (out_valid && lat == 0) lat = i;
        end
        chk("valid_latency", 64'(lat), 64'(SYNC_STAGES + 2));
        chk("pulse_data",  64'(out_data), 64'd100);
        chk("pulse_ovf",   64'(out_ovf), 64'd0);
        chk("pulse_level", 64'(level), 64'd1);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        chk("empty_after_pop", 64'(out_valid), 64'd0);

        // Six events into a stalled FIFO
        for (int e = 0; e < 6; e++) begin count = W'(1000 + e); pulse(2, 4); end
        chk("stall_level", 64'(level), 64'd4);
        chk("stall_drops", 64'(drop_cnt), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 64'(out_data), 64'(1000 + i));
            cycle();
        end
        chk("drained_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Full FIFO with a pop in the capture cycle
        for (int e = 0; e < 4; e++) begin count = W'(2000 + e); pulse(2, 4); end
        chk("refill_level", 64'(level), 64'd4);
        count = W'(2004); event_in = 1'b1;
        for (int i = 1; i <= SYNC_STAGES + 4; i++) begin
            out_ready = (i == SYNC_STAGES + 1);
            if (i == 3) event_in = 1'b0;
            cycle();
        end
        out_ready = 1'b0;
        chk("full_pop_no_drop", 64'(drop_cnt), 64'd2);
        chk("full_pop_level",   64'(level), 64'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("full_pop_order", 64'(out_data), 64'(2000 + i));
            cycle();
        end
        out_ready = 1'b0;

        // Overflow flag captured with the count
        count = 32'hFFFF_FFF0; overflow = 1'b1; pulse(2, 4); overflow = 1'b0;
        chk("ovf_flag",  64'(out_ovf), 64'd1);
        chk("ovf_data",  64'(out_data), 64'hFFFF_FFF0);
        chk("ovf_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // Drop counter saturation and clear
        for (int e = 0; e < 304; e++) begin count = W'($urandom); pulse(1, 1); end
        repeat (4) cycle();
        chk("drop_saturate", 64'(drop_cnt), 64'd255);
        chk("drop_full_lvl", 64'(level), 64'd4);
        drop_clr = 1'b1; cycle(); drop_clr = 1'b0;
        chk("drop_clear", 64'(drop_cnt), 64'd0);
        out_ready = 1'b1; repeat (6) cycle(); out_ready = 1'b0;

        // Asynchronous reset with entries queued
        for (int e = 0; e < 3; e++) begin count = W'(3000 + e); pulse(2, 4); end
        chk("pre_reset_level", 64'(level), 64'd3);
        #2 reset = 1'b1; model_reset();
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_level", 64'(level), 64'd0);
        chk("async_reset_data",  64'(out_data), 64'd0);
        cycle(); cycle();
        reset = 1'b0;
        repeat (2) cycle();
        count = W'(4000); pulse(2, 6);
        chk("post_reset_valid", 64'(out_valid), 64'd1);
        chk("post_reset_data",  64'(out_data), 64'd4000);
        chk("post_reset_level", 64'(level), 64'd1);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // Randomised traffic; alternate blocks bias towards filling or draining
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) event_in = ~event_in;
            if (((i / 500) % 2) == 1) out_ready = ($urandom_range(0, 3) == 0);
            else out_ready = ($urandom_range(0, 3) != 0);
            drop_clr = ($urandom_range(0, 40) == 0);
            count    = W'($urandom);
            overflow = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
